kernel_cc_wb_start_arbiter: RTL and testbench
=============================================

# kernel_cc_wb_start_arbiter

Round-robin start-token arbiter that shares one `write_back` dataflow process among `NUM_REQ` producer processes. Each producer signals work by pushing a 1-bit token into its own start FIFO (shift-register FIFO, empty_n/read side). This block performs four steps:
- pops one token at a time from those FIFOs;
- launches `write_back` with an ap_ctrl_hs handshake;
- holds the winner's ID until completion;
- reports which requester finished.

It sits between the producer start FIFOs and the `write_back` control port inside the `kernel_cc` dataflow region.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requester start FIFOs; legal range 2..8.
- `ID_WIDTH`, default 2: width of requester IDs; must be ≥ clog2(NUM_REQ).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: when low, no new grant is issued; an in-flight launch completes normally.
- `req_empty_n` in NUM_REQ: per-requester start FIFO non-empty.
- `req_read` out NUM_REQ: one-hot, single-cycle pop to the winning FIFO (FIFO read_ce tied high externally).
- `wb_ap_start` out 1: write_back start.
- `wb_ap_ready` in 1: write_back accepted start.
- `wb_ap_done` in 1: write_back finished.
- `grant_valid` out 1: a launch is in flight.
- `grant_id` out ID_WIDTH: ID of the in-flight requester.
- `done_pulse` out 1: one-cycle completion strobe.
- `done_id` out ID_WIDTH: requester that completed; valid with `done_pulse`.
- `launch_cnt` out 32: present only with stats (see Configuration).
- `stall_cnt` out 32: present only with stats (see Configuration).

## Operation
- States: IDLE, START, BUSY.
- Round-robin pointer `last` (ID_WIDTH bits):
  - reset value NUM_REQ-1, so requester 0 has first priority;
  - search order is last+1, last+2, … modulo NUM_REQ;
  - `last` updates to the winner on each grant.
- IDLE:
  - Condition: `enable`=1 and any `req_empty_n` bit is set.
  - Winner w is chosen combinationally; `req_read[w]`=1 in this cycle.
  - `grant_id`<=w, `grant_valid`<=1, go to START.
- START:
  - `wb_ap_start`=1, held until `wb_ap_ready`.
  - `wb_ap_ready`=1 and `wb_ap_done`=0: go to BUSY.
  - `wb_ap_done`=1 in the same cycle (with or without `wb_ap_ready`): treated as ready+done; completion, go to IDLE.
- BUSY:
  - `wb_ap_start`=0; wait for `wb_ap_done`, then completion and go to IDLE.
- Completion:
  - registered `done_pulse`<=1 and `done_id`<=`grant_id` for exactly one cycle;
  - `grant_valid`<=0.
- `req_empty_n` is sampled only in IDLE. This prevents a double pop during the FIFO's one-cycle empty_n update lag.
- `req_read` is never asserted outside IDLE, never for more than one bit, and never for a bit whose `req_empty_n`=0.
- `enable` falling mid-launch has no effect until the block returns to IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `req_read`=0, `wb_ap_start`=0, `grant_valid`=0;
  - `grant_id`=0, `done_pulse`=0, `done_id`=0;
  - counters=0; `last`=NUM_REQ-1.
- Reset asserted mid-START or mid-BUSY:
  - forces the reset values next edge;
  - the popped token is discarded (the whole dataflow region is reset together);
  - no `done_pulse` is generated.
- Launch latency: `req_empty_n` seen in IDLE at cycle T gives `req_read` at T and `wb_ap_start` from T+1.
- Completion latency: `wb_ap_done` at cycle D gives `done_pulse` at D+1.
- Back-to-back: with a token pending, the next `req_read` occurs at D+1 and the next `wb_ap_start` at D+2.
- Minimum spacing between grants is therefore 2 cycles.

## Configuration
- Macro `KERNEL_CC_WB_ARB_STATS_EN`.
- Defined: `launch_cnt` and `stall_cnt` are present.
  - `launch_cnt` increments on each grant.
  - `stall_cnt` increments each cycle where any `req_empty_n` bit is set but no grant issues, i.e. state≠IDLE or `enable`=0.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- Single requester:
  - stimulus: `req_empty_n`=0001; ready at T+3; done at T+6;
  - required: `req_read`=0001 at T; `wb_ap_start` high T+1..T+3; `done_pulse` with `done_id`=0 at T+7.
- Round-robin:
  - stimulus: `req_empty_n`=1111 held; ready+done each launch;
  - required: grant order 0,1,2,3,0; each `req_read` is one-hot; grants spaced 2 cycles apart.
- Enable gating:
  - stimulus: `enable`=0 with `req_empty_n`=0100 for 10 cycles, then `enable`=1;
  - required: no `req_read` while disabled; grant to ID 2 in the first enabled cycle; `stall_cnt`=10 when stats enabled.
- Ready and done in the same cycle:
  - stimulus: `wb_ap_ready` and `wb_ap_done` both 1 in the first START cycle;
  - required: BUSY is skipped; `done_pulse` on the next cycle; the next grant in that same cycle.
- Reset mid-BUSY:
  - stimulus: reset asserted while `grant_valid`=1;
  - required: all outputs at reset values next cycle; no `done_pulse`; next grant goes to requester 0.
- Counter saturation (stats build):
  - stimulus: force `launch_cnt` to 0xFFFFFFFE, then perform 3 launches;
  - required: `launch_cnt` ends at 0xFFFFFFFF.

Source files
------------

// File: rtl/kernel_cc_wb_start_arbiter.sv
// -----------------------------------------------------------------------------
// kernel_cc_wb_start_arbiter
//
// Round-robin start-token arbiter. Several producer processes share one
// write_back dataflow process. Each producer pushes 1-bit start tokens into its
// own shift-register FIFO. This block works as follows:
//   - it pops one token at a time;
//   - it launches write_back through an ap_ctrl_hs handshake;
//   - it holds the winner's ID while the launch is in flight;
//   - it reports which requester completed.
//
// Optional statistics counters are compiled in when the macro
// KERNEL_CC_WB_ARB_STATS_EN is defined.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   enable       in   low: no new grant (an in-flight launch still completes)
//   req_empty_n  in   [NUM_REQ]  per-requester start FIFO non-empty
//   req_read     out  [NUM_REQ]  one-hot single-cycle pop of the winning FIFO
//   wb_ap_start  out  write_back ap_start
//   wb_ap_ready  in   write_back ap_ready
//   wb_ap_done   in   write_back ap_done
//   grant_valid  out  a launch is in flight
//   grant_id     out  [ID_WIDTH] ID of the in-flight requester
//   done_pulse   out  one-cycle completion strobe
//   done_id      out  [ID_WIDTH] requester that completed, valid with done_pulse
//   launch_cnt   out  [32] saturating grant count        (stats build only)
//   stall_cnt    out  [32] saturating stalled-cycle count (stats build only)
// -----------------------------------------------------------------------------
module kernel_cc_wb_start_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_REQ-1:0]  req_empty_n,
    output logic [NUM_REQ-1:0]  req_read,
    output logic                wb_ap_start,
    input  logic                wb_ap_ready,
    input  logic                wb_ap_done,
    output logic                grant_valid,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                done_pulse,
    output logic [ID_WIDTH-1:0] done_id
`ifdef KERNEL_CC_WB_ARB_STATS_EN
    ,
    output logic [31:0]         launch_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    // One extra bit holds last+offset before the modulo wrap (max 2*NUM_REQ-1).
    localparam int PW = ID_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [ID_WIDTH-1:0] last_reg;
    logic                grant_valid_reg;
    logic [ID_WIDTH-1:0] grant_id_reg;
    logic                done_pulse_reg;
    logic [ID_WIDTH-1:0] done_id_reg;

    logic                grant;
    logic                complete;

    // ------------------------------------------------------------------
    // Round-robin candidate search. Candidate gi is requester
    // (last + 1 + gi) mod NUM_REQ. The lowest-numbered candidate that has
    // a token wins.
    // ------------------------------------------------------------------
    logic [PW-1:0]       cand_sum  [NUM_REQ];
    logic [PW-1:0]       cand_pos  [NUM_REQ];
    logic [ID_WIDTH-1:0] cand_id   [NUM_REQ];
    logic [NUM_REQ-1:0]  cand_mask [NUM_REQ];
    logic [NUM_REQ-1:0]  cand_hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_sum[gi]  = {1'b0, last_reg} + PW'(gi + 1);
            assign cand_pos[gi]  = (cand_sum[gi] >= PW'(NUM_REQ)) ?
                                   (cand_sum[gi] - PW'(NUM_REQ)) : cand_sum[gi];
            assign cand_id[gi]   = cand_pos[gi][ID_WIDTH-1:0];
            assign cand_mask[gi] = NUM_REQ'(1) << cand_pos[gi];
            assign cand_hit[gi]  = |(req_empty_n & cand_mask[gi]);
        end
    endgenerate

    logic                win_found;
    logic [ID_WIDTH-1:0] win_id;
    logic [NUM_REQ-1:0]  win_mask;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_mask  = '0;
        // Descending scan so the nearest candidate (smallest offset) wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_found = 1'b1;
                win_id    = cand_id[k];
                win_mask  = cand_mask[k];
            end
        end
    end

    // req_empty_n is sampled only in IDLE. The FIFO lowers empty_n one cycle
    // after the pop, so sampling it in any later state could pop twice.
    assign grant = (state_reg == IDLE) && enable && win_found && !reset;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        complete    = 1'b0;
        wb_ap_start = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next = START;
                end
            end
            START: begin
                wb_ap_start = 1'b1;
                // A done seen while still starting counts as ready+done.
                if (wb_ap_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wb_ap_ready) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (wb_ap_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping and completion reporting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg        <= ID_WIDTH'(NUM_REQ - 1);
            grant_valid_reg <= 1'b0;
            grant_id_reg    <= '0;
            done_pulse_reg  <= 1'b0;
            done_id_reg     <= '0;
        end else begin
            done_pulse_reg <= complete;
            if (complete) begin
                done_id_reg <= grant_id_reg;
            end
            if (grant) begin
                last_reg        <= win_id;
                grant_id_reg    <= win_id;
                grant_valid_reg <= 1'b1;
            end else if (complete) begin
                grant_valid_reg <= 1'b0;
            end
        end
    end

    assign req_read    = grant ? win_mask : '0;
    assign grant_valid = grant_valid_reg;
    assign grant_id    = grant_id_reg;
    assign done_pulse  = done_pulse_reg;
    assign done_id     = done_id_reg;

`ifdef KERNEL_CC_WB_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics. A stall is a cycle with a token waiting but
    // no grant (busy or disabled).
    // ------------------------------------------------------------------
    logic [31:0] launch_cnt_reg;
    logic [31:0] stall_cnt_reg;
    logic        stall;

    assign stall = (|req_empty_n) && !grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            launch_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (grant && (launch_cnt_reg != 32'hFFFF_FFFF)) begin
                launch_cnt_reg <= launch_cnt_reg + 32'd1;
            end
            if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign launch_cnt = launch_cnt_reg;
    assign stall_cnt  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_kernel_cc_wb_start_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for kernel_cc_wb_start_arbiter (NUM_REQ=4, ID_WIDTH=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected grant masks and done IDs are queued when stimulus is
// driven. A monitor pops the queues when the DUT pulses req_read or done_pulse.
// -----------------------------------------------------------------------------
module tb_kernel_cc_wb_start_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req_empty_n;
    logic [3:0] req_read;
    logic       wb_ap_start;
    logic       wb_ap_ready;
    logic       wb_ap_done;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       done_pulse;
    logic [1:0] done_id;
`ifdef KERNEL_CC_WB_ARB_STATS_EN
    logic [31:0] launch_cnt;
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_grant_q[$];
    logic [1:0] exp_done_q[$];

    always #5 clk = ~clk;

    kernel_cc_wb_start_arbiter #(
        .NUM_REQ (4),
        .ID_WIDTH(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_empty_n(req_empty_n),
        .req_read   (req_read),
        .wb_ap_start(wb_ap_start),
        .wb_ap_ready(wb_ap_ready),
        .wb_ap_done (wb_ap_done),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .done_pulse (done_pulse),
        .done_id    (done_id)
`ifdef KERNEL_CC_WB_ARB_STATS_EN
        ,
        .launch_cnt (launch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next();
        reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    // Scoreboard monitor plus the req_read safety invariants.
    always @(negedge clk) begin
        logic [3:0] eg;
        logic [1:0] ed;
        check("rd_onehot", ((req_read & (req_read - 4'd1)) == 4'd0), 1'b1);
        check("rd_subset", (req_read & ~req_empty_n), 4'd0);
        if (!reset) begin
            if (req_read != 4'd0) begin
                if (exp_grant_q.size() == 0) begin
                    check("unexpected_grant", req_read, 4'd0);
                end else begin
                    eg = exp_grant_q.pop_front();
                    check("grant_mask", req_read, eg);
                    $display("grant: req_read=%b expected=%b", req_read, eg);
                end
            end
            if (done_pulse) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", done_pulse, 1'b0);
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done_id", done_id, ed);
                    $display("done:  done_id=%0d expected=%0d", done_id, ed);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; req_empty_n = 4'd0;
        wb_ap_ready = 1'b0; wb_ap_done = 1'b0;
        repeat (3) next();
        mid();
        check("rst_req_read",    req_read,    4'd0);
        check("rst_start",       wb_ap_start, 1'b0);
        check("rst_grant_valid", grant_valid, 1'b0);
        check("rst_grant_id",    grant_id,    2'd0);
        check("rst_done_pulse",  done_pulse,  1'b0);
        check("rst_done_id",     done_id,     2'd0);
`ifdef KERNEL_CC_WB_ARB_STATS_EN
        check("rst_launch_cnt",  launch_cnt,  32'd0);
        check("rst_stall_cnt",   stall_cnt,   32'd0);
`endif
        next(); reset = 1'b0; enable = 1'b1;

        // ---- Single requester: ready at T+3, done at T+6 ----
        next(); req_empty_n = 4'b0001;
        exp_grant_q.push_back(4'b0001); exp_done_q.push_back(2'd0);
        mid(); check("s_T_start", wb_ap_start, 1'b0);
        next(); req_empty_n = 4'b0000;
        mid(); check("s_T1_start", wb_ap_start, 1'b1);
               check("s_T1_gvalid", grant_valid, 1'b1);
               check("s_T1_gid", grant_id, 2'd0);
        next();
        mid(); check("s_T2_start", wb_ap_start, 1'b1);
        next(); wb_ap_ready = 1'b1;
        mid(); check("s_T3_start", wb_ap_start, 1'b1);
        next(); wb_ap_ready = 1'b0;
        mid(); check("s_T4_start", wb_ap_start, 1'b0);
               check("s_T4_gvalid", grant_valid, 1'b1);
        next();
        mid(); check("s_T5_done", done_pulse, 1'b0);
        next(); wb_ap_done = 1'b1;
        mid(); check("s_T6_done", done_pulse, 1'b0);
        next(); wb_ap_done = 1'b0;
        mid(); check("s_T7_done", done_pulse, 1'b1);
               check("s_T7_gvalid", grant_valid, 1'b0);
        next();
        mid(); check("s_T8_done", done_pulse, 1'b0);

        // ---- Round-robin with all requesters pending ----
        do_reset();
        req_empty_n = 4'b1111; wb_ap_ready = 1'b1; wb_ap_done = 1'b1;
        exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b1000);
        exp_grant_q.push_back(4'b0001);
        exp_done_q.push_back(2'd0); exp_done_q.push_back(2'd1);
        exp_done_q.push_back(2'd2); exp_done_q.push_back(2'd3);
        exp_done_q.push_back(2'd0);
        for (int i = 0; i < 10; i++) begin
            mid();
            check("rr_spacing", (req_read != 4'd0), ((i % 2) == 0));
            next();
            if (i == 8) req_empty_n = 4'b0000;
        end
        wb_ap_ready = 1'b0; wb_ap_done = 1'b0;
        mid(); check("rr_last_done", done_pulse, 1'b1);

        // ---- Enable gating for 10 cycles ----
        do_reset();
        enable = 1'b0; req_empty_n = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            mid();
            check("en_blocked", req_read, 4'd0);
            next();
        end
        enable = 1'b1;
        exp_grant_q.push_back(4'b0100); exp_done_q.push_back(2'd2);
        mid(); check("en_grant", req_read, 4'b0100);
`ifdef KERNEL_CC_WB_ARB_STATS_EN
        check("en_stall_cnt", stall_cnt, 32'd10);
`endif

        // ---- Ready and done together in the first START cycle ----
        next(); req_empty_n = 4'b0000; wb_ap_ready = 1'b1; wb_ap_done = 1'b1;
        mid(); check("rd_start", wb_ap_start, 1'b1);
               check("rd_gid", grant_id, 2'd2);
        next(); wb_ap_ready = 1'b0; wb_ap_done = 1'b0; req_empty_n = 4'b1001;
        exp_grant_q.push_back(4'b1000);   // last=2: search 3,0,... -> 3
        mid(); check("rd_pulse", done_pulse, 1'b1);
               check("rd_no_busy", wb_ap_start, 1'b0);
               check("rd_gvalid", grant_valid, 1'b0);
               check("rd_regrant", req_read, 4'b1000);

        // ---- Reset while BUSY ----
        next(); req_empty_n = 4'b0000;
        mid(); check("rb_start", wb_ap_start, 1'b1);
               check("rb_gid", grant_id, 2'd3);
        next(); wb_ap_ready = 1'b1;
        mid(); check("rb_start2", wb_ap_start, 1'b1);
        next(); wb_ap_ready = 1'b0;
        mid(); check("rb_busy_start", wb_ap_start, 1'b0);
               check("rb_busy_gvalid", grant_valid, 1'b1);
        next(); reset = 1'b1;   // launch for requester 3 is discarded
        mid();
        next(); reset = 1'b0; wb_ap_done = 1'b1;
        mid(); check("rb_req_read", req_read, 4'd0);
               check("rb_start3", wb_ap_start, 1'b0);
               check("rb_gvalid", grant_valid, 1'b0);
               check("rb_gid0", grant_id, 2'd0);
               check("rb_dpulse", done_pulse, 1'b0);
               check("rb_did", done_id, 2'd0);
`ifdef KERNEL_CC_WB_ARB_STATS_EN
               check("rb_launch_cnt", launch_cnt, 32'd0);
`endif
        next(); wb_ap_done = 1'b0;
        mid(); check("rb_no_done", done_pulse, 1'b0);
        next(); req_empty_n = 4'b1111;
        exp_grant_q.push_back(4'b0001); exp_done_q.push_back(2'd0);
        mid(); check("rb_first", req_read, 4'b0001);
        next(); req_empty_n = 4'b0000; wb_ap_ready = 1'b1; wb_ap_done = 1'b1;
        mid();
        next(); wb_ap_ready = 1'b0; wb_ap_done = 1'b0;
        mid(); check("rb_done_after", done_pulse, 1'b1);

`ifdef KERNEL_CC_WB_ARB_STATS_EN
        // ---- Launch counter saturation ----
        next();
        force dut.launch_cnt_reg = 32'hFFFF_FFFE;
        next();
        release dut.launch_cnt_reg;
        for (int i = 0; i < 3; i++) begin
            req_empty_n = 4'b0001; wb_ap_ready = 1'b1; wb_ap_done = 1'b1;
            exp_grant_q.push_back(4'b0001); exp_done_q.push_back(2'd0);
            mid();
            next(); req_empty_n = 4'b0000;
            mid();
            next();
            mid();
            next();
        end
        wb_ap_ready = 1'b0; wb_ap_done = 1'b0;
        mid(); check("sat_launch_cnt", launch_cnt, 32'hFFFF_FFFF);
`endif

        next();
        mid();
        check("grant_q_drained", exp_grant_q.size(), 0);
        check("done_q_drained",  exp_done_q.size(),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
